plab3_mem_l2_tdm_arbiter: RTL and testbench
===========================================

Name: plab3_mem_l2_tdm_arbiter

Overview:
- Shares one L2 cache bank (blocking, one transaction in flight) among p_num_reqs L1 requesters.
- Uses time-division by security domain. Fixed-length epochs alternate domain 0 / domain 1.
- Grants go only to requesters tagged with the current domain, and only inside the epoch's open window. This keeps L2 timing independent of the other domain's traffic.
- Drives the bank's sd input and routes each response back to the granted requester.

Parameters:
- p_num_reqs, 2, number of requesters (2..4).
- p_opaque_nbits, 8, opaque field width.
- p_net_srcdest_nbits, 2, width of requester-id field at the top of opaque.
- p_req_nbits, 175, `VC_MEM_REQ_MSG_NBITS(8,32,128).
- p_resp_nbits, 143, `VC_MEM_RESP_MSG_NBITS(8,128).
- p_epoch_len, 64, cycles per domain epoch.
- p_dead_len, 16, closing cycles of each epoch in which no grant is issued (must be < p_epoch_len).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_req_msg  in  p_num_reqs*p_req_nbits  requester i message at slice i.
- in_req_val  in  p_num_reqs  request valid per requester.
- in_req_rdy  out  p_num_reqs  request ready per requester.
- in_req_dom  in  p_num_reqs  static domain tag per requester.
- out_resp_msg  out  p_resp_nbits  response message, broadcast to all requesters.
- out_resp_val  out  p_num_reqs  response valid, one-hot to the granted requester.
- out_resp_rdy  in  p_num_reqs  response ready per requester.
- cachereq_msg  out  p_req_nbits  request to L2 bank.
- cachereq_val  out  1  request valid to L2 bank.
- cachereq_rdy  in  1  L2 bank request ready.
- cacheresp_msg  in  p_resp_nbits  response from L2 bank.
- cacheresp_val  in  1  L2 bank response valid.
- cacheresp_rdy  out  1  response ready to L2 bank.
- sd  out  1  domain presented to the L2 bank.
- epoch_dom  out  1  current epoch domain.
- overrun  out  1  one-cycle pulse: epoch wrapped while a transaction was in flight.

Behaviour:
- Reset (async) values:
  - epoch_cnt=0, epoch_dom=0, sd=0, state=IDLE, rr_ptr=0, sel=0.
  - All val/rdy outputs 0, overrun=0, msg outputs 0.
- Epoch counter:
  - Free-runs 0..p_epoch_len-1 independent of traffic.
  - At the count p_epoch_len-1 -> 0 wrap, epoch_dom toggles.
  - window_open = (epoch_cnt < p_epoch_len-p_dead_len).
- State machine states: IDLE, SEND, WAIT_RESP.
- IDLE:
  - elig[i] = in_req_val[i] & (in_req_dom[i]==epoch_dom).
  - If window_open and any elig: register sel = first eligible index at or after rr_ptr (wrapping), latch sd_tx=epoch_dom, go to SEND.
  - No input ready asserted in IDLE.
- SEND:
  - cachereq_msg = in_req_msg[sel], cachereq_val = in_req_val[sel], in_req_rdy[sel] = cachereq_rdy.
  - On val&rdy go to WAIT_RESP.
  - If in_req_val[sel] deasserts, return to IDLE without issuing.
- WAIT_RESP:
  - out_resp_msg = cacheresp_msg, out_resp_val[sel] = cacheresp_val, cacheresp_rdy = out_resp_rdy[sel].
  - On fire: rr_ptr = sel+1 mod p_num_reqs, go to IDLE.
- Latency: request sampled valid at cycle n gives cachereq_val at n+1, provided the window is open at n. Earliest re-grant is the cycle after the response fires.
- sd output:
  - Equals sd_tx while not IDLE; equals epoch_dom in IDLE.
  - A transaction in flight keeps its domain across an epoch wrap.
  - At such a wrap, overrun pulses; no new grant until IDLE and the window is open in the correct domain.
- Simultaneous events: a wrap in the same cycle as an IDLE grant decision uses the pre-wrap epoch_dom and epoch_cnt (registered values).
- Only one transaction is outstanding at any time. Responses are never reordered.

Optional Feature:
- Macro: PLAB3_MEM_L2_TDM_ARBITER_OPAQUE_STAMP_EN.
- Defined: the top p_net_srcdest_nbits of the opaque field in cachereq_msg are overwritten with sel. All other bits pass unchanged.
- Undefined: cachereq_msg passes bit-exact. Requesters are responsible for net_src.

Test Plan:
- Reset asserted at cycle 10 during WAIT_RESP -> immediately: all vals/rdys 0, sd=0, epoch_cnt=0. After release: first grant goes to requester 0.
- Requester 0 (dom 0) read 0x1000 valid at cycle 2, bank rdy=1, response at cycle 6 -> cachereq_val at cycle 3, out_resp_val=2'b01 at cycle 6, state IDLE at cycle 7.
- Requester 1 (dom 1) valid at cycle 5 -> no grant until epoch_cnt wraps at cycle 64 (epoch_dom=1). Then cachereq_val at cycle 65 with sd=1.
- Requesters 0 and 1 both dom 0, continuously valid, 1-cycle bank -> grant order 0,1,0,1 within the window. No grant issued while epoch_cnt is 48..63.
- Request at epoch_cnt=50, dom 0 -> held until cycle 128 (next dom-0 window), cachereq_val at cycle 129.
- Grant at cycle 47, cacheresp withheld until cycle 70 -> overrun pulses at cycle 64. sd stays 0 until the response fires at cycle 70, then sd=1.

Source files
------------

// File: rtl/plab3_mem_l2_tdm_arbiter_if.sv
// Requester-side and L2-bank-side signals of the TDM L2 arbiter.
// The arbiter connects through the master modport; the surrounding system uses the slave modport.
interface plab3_mem_l2_tdm_arbiter_if #(
    parameter int unsigned p_num_reqs   = 2,
    parameter int unsigned p_req_nbits  = 175,
    parameter int unsigned p_resp_nbits = 143
);
    logic [p_num_reqs*p_req_nbits-1:0] in_req_msg;
    logic [p_num_reqs-1:0]             in_req_val;
    logic [p_num_reqs-1:0]             in_req_rdy;
    logic [p_num_reqs-1:0]             in_req_dom;
    logic [p_resp_nbits-1:0]           out_resp_msg;
    logic [p_num_reqs-1:0]             out_resp_val;
    logic [p_num_reqs-1:0]             out_resp_rdy;
    logic [p_req_nbits-1:0]            cachereq_msg;
    logic                              cachereq_val;
    logic                              cachereq_rdy;
    logic [p_resp_nbits-1:0]           cacheresp_msg;
    logic                              cacheresp_val;
    logic                              cacheresp_rdy;
    logic                              sd;
    logic                              epoch_dom;
    logic                              overrun;

    modport master (
        input  in_req_msg, in_req_val, in_req_dom, out_resp_rdy,
        input  cachereq_rdy, cacheresp_msg, cacheresp_val,
        output in_req_rdy, out_resp_msg, out_resp_val,
        output cachereq_msg, cachereq_val, cacheresp_rdy,
        output sd, epoch_dom, overrun
    );

    modport slave (
        output in_req_msg, in_req_val, in_req_dom, out_resp_rdy,
        output cachereq_rdy, cacheresp_msg, cacheresp_val,
        input  in_req_rdy, out_resp_msg, out_resp_val,
        input  cachereq_msg, cachereq_val, cacheresp_rdy,
        input  sd, epoch_dom, overrun
    );
endinterface

// File: rtl/plab3_mem_l2_tdm_arbiter.sv
// Time-division L2 bank arbiter: alternating per-domain epochs, one transaction in flight.
// Define PLAB3_MEM_L2_TDM_ARBITER_OPAQUE_STAMP_EN to stamp the requester id into the opaque field.
module plab3_mem_l2_tdm_arbiter #(
    parameter int unsigned p_num_reqs          = 2,
    parameter int unsigned p_opaque_nbits      = 8,
    parameter int unsigned p_net_srcdest_nbits = 2,
    parameter int unsigned p_req_nbits         = 175,
    parameter int unsigned p_resp_nbits        = 143,
    parameter int unsigned p_epoch_len         = 64,
    parameter int unsigned p_dead_len          = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    plab3_mem_l2_tdm_arbiter_if.master   bus
);

    localparam int unsigned SelW    = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;
    localparam int unsigned EpochW  = (p_epoch_len > 1) ? $clog2(p_epoch_len) : 1;
    localparam int unsigned OpenLen = p_epoch_len - p_dead_len;
    // Request layout is {type(3), opaque, addr, len, data}.
    localparam int unsigned OpaqueLsb = p_req_nbits - 3 - p_opaque_nbits;
    localparam int unsigned OpaqueMsb = OpaqueLsb + p_opaque_nbits - 1;
    localparam logic [EpochW-1:0] EpochLast = EpochW'(p_epoch_len - 1);

`ifdef PLAB3_MEM_L2_TDM_ARBITER_OPAQUE_STAMP_EN
    localparam bit StampEn = 1'b1;
`else
    localparam bit StampEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StSend, StWaitResp} state_e;

    state_e              state_q, state_d;
    logic [EpochW-1:0]   epoch_cnt_q, epoch_cnt_d;
    logic                epoch_dom_q, epoch_dom_d;
    logic                sd_tx_q, sd_tx_d;
    logic [SelW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SelW-1:0]     sel_q, sel_d;
    logic                overrun_q, overrun_d;

    logic                epoch_wrap;
    logic                window_open;
    logic [p_num_reqs-1:0] elig;
    logic                found_hi, found_any;
    logic [SelW-1:0]     idx_hi, idx_any, grant_idx;
    logic                req_val_sel, resp_rdy_sel;
    logic [p_req_nbits-1:0] req_msg_sel, req_msg_fwd;

    logic [p_num_reqs-1:0]   in_req_rdy;
    logic [p_num_reqs-1:0]   out_resp_val;
    logic [p_resp_nbits-1:0] out_resp_msg;
    logic [p_req_nbits-1:0]  cachereq_msg;
    logic                    cachereq_val;
    logic                    cacheresp_rdy;

    // Epoch timing runs regardless of traffic so grant slots never depend on the other domain.
    always_comb begin
        epoch_wrap  = (epoch_cnt_q == EpochLast);
        epoch_cnt_d = epoch_wrap ? '0 : epoch_cnt_q + 1'b1;
        epoch_dom_d = epoch_dom_q ^ epoch_wrap;
        window_open = (32'(epoch_cnt_q) < OpenLen);
        elig        = bus.in_req_val & ~(bus.in_req_dom ^ {p_num_reqs{epoch_dom_q}});
    end

    // Round-robin pick: first eligible at or after rr_ptr, else first eligible overall.
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        idx_hi    = '0;
        idx_any   = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (elig[i] && !found_any) begin
                found_any = 1'b1;
                idx_any   = SelW'(i);
            end
            if (elig[i] && !found_hi && (i >= int'(rr_ptr_q))) begin
                found_hi = 1'b1;
                idx_hi   = SelW'(i);
            end
        end
        grant_idx = found_hi ? idx_hi : idx_any;
    end

    always_comb begin
        req_val_sel  = 1'b0;
        resp_rdy_sel = 1'b0;
        req_msg_sel  = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (sel_q == SelW'(i)) begin
                req_val_sel  = bus.in_req_val[i];
                resp_rdy_sel = bus.out_resp_rdy[i];
                req_msg_sel  = bus.in_req_msg[i*p_req_nbits +: p_req_nbits];
            end
        end
        req_msg_fwd = req_msg_sel;
        if (StampEn) begin
            req_msg_fwd[OpaqueMsb -: p_net_srcdest_nbits] = p_net_srcdest_nbits'(sel_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        sd_tx_d  = sd_tx_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                // Registered epoch values: a wrap in this cycle does not affect the decision.
                if (window_open && found_any) begin
                    sel_d   = grant_idx;
                    sd_tx_d = epoch_dom_q;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!req_val_sel) begin
                    state_d = StIdle;
                end else if (bus.cachereq_rdy) begin
                    state_d = StWaitResp;
                end
            end
            StWaitResp: begin
                if (bus.cacheresp_val && resp_rdy_sel) begin
                    rr_ptr_d = (sel_q == SelW'(p_num_reqs - 1)) ? '0 : sel_q + 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        overrun_d = epoch_wrap && (state_d != StIdle);
    end

    always_comb begin
        in_req_rdy    = '0;
        out_resp_val  = '0;
        out_resp_msg  = '0;
        cachereq_msg  = '0;
        cachereq_val  = 1'b0;
        cacheresp_rdy = 1'b0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (sel_q == SelW'(i)) begin
                in_req_rdy[i]   = (state_q == StSend) && bus.cachereq_rdy;
                out_resp_val[i] = (state_q == StWaitResp) && bus.cacheresp_val;
            end
        end
        if (state_q == StSend) begin
            cachereq_msg = req_msg_fwd;
            cachereq_val = req_val_sel;
        end
        if (state_q == StWaitResp) begin
            out_resp_msg  = bus.cacheresp_msg;
            cacheresp_rdy = resp_rdy_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            epoch_cnt_q <= '0;
            epoch_dom_q <= 1'b0;
            sd_tx_q     <= 1'b0;
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            epoch_cnt_q <= epoch_cnt_d;
            epoch_dom_q <= epoch_dom_d;
            sd_tx_q     <= sd_tx_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.in_req_rdy    = in_req_rdy;
    assign bus.out_resp_val  = out_resp_val;
    assign bus.out_resp_msg  = out_resp_msg;
    assign bus.cachereq_msg  = cachereq_msg;
    assign bus.cachereq_val  = cachereq_val;
    assign bus.cacheresp_rdy = cacheresp_rdy;
    // An in-flight transaction keeps its own domain on the bank's sd input.
    assign bus.sd            = (state_q == StIdle) ? epoch_dom_q : sd_tx_q;
    assign bus.epoch_dom     = epoch_dom_q;
    assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_plab3_mem_l2_tdm_arbiter.sv
// Bench for plab3_mem_l2_tdm_arbiter: directed timing scenarios plus randomized traffic
// checked each cycle against a transaction-level model using cycle-count epoch arithmetic.
module tb_plab3_mem_l2_tdm_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned RQ = 175;
    localparam int unsigned RS = 143;
    localparam int unsigned EL = 64;
    localparam int unsigned DL = 16;
    localparam int unsigned SD = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    plab3_mem_l2_tdm_arbiter_if #(.p_num_reqs(N), .p_req_nbits(RQ), .p_resp_nbits(RS)) bus ();

    plab3_mem_l2_tdm_arbiter #(
        .p_num_reqs(N), .p_opaque_nbits(8), .p_net_srcdest_nbits(SD), .p_req_nbits(RQ),
        .p_resp_nbits(RS), .p_epoch_len(EL), .p_dead_len(DL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int t;

    // Model: phase 0 = no transaction, 1 = granted awaiting bank accept, 2 = awaiting response.
    int          phase, m_sel, rr;
    logic        m_dom;
    logic [N-1:0] pend, dom_cfg;
    logic [RQ-1:0] rq_msg [N];
    bit          bank_busy;
    int          bank_cnt;
    logic [RS-1:0] bank_msg;
    int unsigned req_pct, rdy_pct, rsp_pct;
    bit          keep_busy, long_delays;
    int          delay_q[$];

    // Events observed on the DUT ports.
    int          fire_cyc[$], fire_sel[$], resp_cyc[$], ovr_cyc[$];
    logic        fire_sd[$], sd_at[$];
    logic [N-1:0] resp_vec[$];

    task automatic check_eq(input string tag, input logic [RQ-1:0] got, input logic [RQ-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (t=%0d): got 0x%0h, expected 0x%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [RQ-1:0] rand_req();
        logic [191:0] r;
        r = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
             32'($urandom)};
        return r[RQ-1:0];
    endfunction

    function automatic logic [RS-1:0] rand_resp();
        logic [159:0] r;
        r = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        return r[RS-1:0];
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && (keep_busy || $urandom_range(99) < req_pct)) begin
                pend[i]   = 1'b1;
                rq_msg[i] = rand_req();
            end
            bus.in_req_msg[i*RQ +: RQ] = rq_msg[i];
            bus.out_resp_rdy[i] = ($urandom_range(99) < rsp_pct);
        end
        bus.in_req_val   = pend;
        bus.in_req_dom   = dom_cfg;
        bus.cachereq_rdy = ($urandom_range(99) < rdy_pct);
        if (bank_busy && bank_cnt == 0) begin
            bus.cacheresp_val = 1'b1;
            bus.cacheresp_msg = bank_msg;
        end else begin
            bus.cacheresp_val = 1'b0;
            bus.cacheresp_msg = rand_resp();
        end
    endtask

    task automatic sample_step();
        int unsigned  cnt;
        logic         edom, e_cval, e_crdy, e_sd, e_ovr;
        logic [N-1:0] e_inrdy, e_rval;
        logic [RQ-1:0] e_cmsg;
        logic [RS-1:0] e_rmsg;
        bit           found;
        int           dsel, cand;
        cnt     = t % EL;
        edom    = ((t / EL) % 2) == 1;
        e_cval  = 1'b0;
        e_crdy  = 1'b0;
        e_inrdy = '0;
        e_rval  = '0;
        e_cmsg  = '0;
        e_rmsg  = '0;
        e_sd    = edom;
        e_ovr   = (t > 0) && (cnt == 0) && (phase != 0);
        if (phase == 1) begin
            e_cval          = pend[m_sel];
            e_inrdy[m_sel]  = bus.cachereq_rdy;
            e_cmsg          = rq_msg[m_sel];
`ifdef PLAB3_MEM_L2_TDM_ARBITER_OPAQUE_STAMP_EN
            e_cmsg[RQ-4 -: SD] = SD'(m_sel);
`endif
            e_sd            = m_dom;
        end else if (phase == 2) begin
            e_rval[m_sel] = bus.cacheresp_val;
            e_rmsg        = bus.cacheresp_msg;
            e_crdy        = bus.out_resp_rdy[m_sel];
            e_sd          = m_dom;
        end
        check_eq("epoch_dom", bus.epoch_dom, edom);
        check_eq("overrun", bus.overrun, e_ovr);
        check_eq("sd", bus.sd, e_sd);
        check_eq("cachereq_val", bus.cachereq_val, e_cval);
        check_eq("cachereq_msg", bus.cachereq_msg, e_cmsg);
        check_eq("in_req_rdy", bus.in_req_rdy, e_inrdy);
        check_eq("out_resp_val", bus.out_resp_val, e_rval);
        check_eq("out_resp_msg", bus.out_resp_msg, e_rmsg);
        check_eq("cacheresp_rdy", bus.cacheresp_rdy, e_crdy);

        sd_at.push_back(bus.sd);
        if (bus.cachereq_val && bus.cachereq_rdy) begin
            dsel = -1;
            for (int i = 0; i < N; i++) if (bus.in_req_rdy[i]) dsel = i;
            fire_cyc.push_back(t);
            fire_sel.push_back(dsel);
            fire_sd.push_back(bus.sd);
        end
        if ((bus.out_resp_val & bus.out_resp_rdy) != '0) begin
            resp_cyc.push_back(t);
            resp_vec.push_back(bus.out_resp_val);
        end
        if (bus.overrun) ovr_cyc.push_back(t);

        if (bank_busy && bank_cnt > 0) bank_cnt--;
        case (phase)
            0: if (cnt < EL - DL) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    cand = (rr + k) % N;
                    if (!found && pend[cand] && dom_cfg[cand] == edom) begin
                        found = 1'b1;
                        m_sel = cand;
                        m_dom = edom;
                        phase = 1;
                    end
                end
            end
            1: if (!pend[m_sel]) begin
                phase = 0;
            end else if (bus.cachereq_rdy) begin
                pend[m_sel] = 1'b0;
                phase       = 2;
                bank_busy   = 1'b1;
                bank_msg    = rand_resp();
                if (delay_q.size() > 0) bank_cnt = delay_q.pop_front();
                else if (long_delays && $urandom_range(9) == 0) bank_cnt = $urandom_range(40);
                else bank_cnt = $urandom_range(3);
            end
            2: if (bus.cacheresp_val && bus.out_resp_rdy[m_sel]) begin
                phase     = 0;
                rr        = (m_sel + 1) % N;
                bank_busy = 1'b0;
            end
            default: phase = 0;
        endcase
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            drive();
            @(negedge clk);
            sample_step();
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_cachereq_val", bus.cachereq_val, 1'b0);
        check_eq("rst_in_req_rdy", bus.in_req_rdy, '0);
        check_eq("rst_out_resp_val", bus.out_resp_val, '0);
        check_eq("rst_cacheresp_rdy", bus.cacheresp_rdy, 1'b0);
        check_eq("rst_sd", bus.sd, 1'b0);
        check_eq("rst_epoch_dom", bus.epoch_dom, 1'b0);
        check_eq("rst_overrun", bus.overrun, 1'b0);
        check_eq("rst_cachereq_msg", bus.cachereq_msg, '0);
        pend = '0; phase = 0; rr = 0; m_sel = 0; m_dom = 1'b0;
        bank_busy = 1'b0; bank_cnt = 0; delay_q.delete();
        fire_cyc.delete(); fire_sel.delete(); fire_sd.delete(); resp_cyc.delete();
        resp_vec.delete(); ovr_cyc.delete(); sd_at.delete();
        keep_busy = 1'b0; long_delays = 1'b0; req_pct = 0; rdy_pct = 100; rsp_pct = 100;
        bus.in_req_val = '0; bus.cacheresp_val = 1'b0; bus.cachereq_rdy = 1'b0;
        bus.out_resp_rdy = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        t = 0;
    endtask

    initial begin
        reset = 1'b1;
        t = 0;
        dom_cfg = '0;
        for (int i = 0; i < N; i++) rq_msg[i] = '0;
        bus.in_req_msg = '0; bus.in_req_dom = '0; bus.cacheresp_msg = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Requester 0 read 0x1000 valid at cycle 2, response at cycle 6.
        dom_cfg = 2'b00;
        run_cycles(2);
        pend[0] = 1'b1;
        rq_msg[0] = rand_req();
        rq_msg[0][163:132] = 32'h1000;
        delay_q.push_back(2);
        run_cycles(8);
        check_eq("basic_req_cyc", (fire_cyc.size() > 0) ? fire_cyc[0] : -1, 3);
        check_eq("basic_req_sel", (fire_sel.size() > 0) ? fire_sel[0] : -1, 0);
        check_eq("basic_resp_cyc", (resp_cyc.size() > 0) ? resp_cyc[0] : -1, 6);
        check_eq("basic_resp_vec", (resp_vec.size() > 0) ? resp_vec[0] : 2'b11, 2'b01);

        // Domain-1 requester waits for the first domain-1 epoch.
        do_reset();
        dom_cfg = 2'b10;
        run_cycles(5);
        pend[1] = 1'b1;
        rq_msg[1] = rand_req();
        run_cycles(70);
        check_eq("dom1_req_cyc", (fire_cyc.size() > 0) ? fire_cyc[0] : -1, 65);
        check_eq("dom1_req_sel", (fire_sel.size() > 0) ? fire_sel[0] : -1, 1);
        check_eq("dom1_req_sd", (fire_sd.size() > 0) ? fire_sd[0] : 1'b0, 1'b1);

        // Round robin with both requesters in domain 0, continuously valid.
        do_reset();
        dom_cfg = 2'b00;
        keep_busy = 1'b1;
        for (int i = 0; i < 40; i++) delay_q.push_back(0);
        run_cycles(130);
        for (int i = 0; i < 4; i++)
            check_eq("rr_order", (fire_sel.size() > i) ? fire_sel[i] : -1, i % 2);
        foreach (fire_cyc[i])
            check_eq("rr_dead_window", ((fire_cyc[i] - 1) % EL) < (EL - DL), 1'b1);

        // Request during the dead window waits for the next domain-0 window.
        do_reset();
        dom_cfg = 2'b00;
        run_cycles(50);
        pend[0] = 1'b1;
        rq_msg[0] = rand_req();
        run_cycles(85);
        check_eq("dead_req_cyc", (fire_cyc.size() > 0) ? fire_cyc[0] : -1, 129);

        // Transaction straddling an epoch wrap.
        do_reset();
        dom_cfg = 2'b00;
        run_cycles(47);
        pend[0] = 1'b1;
        rq_msg[0] = rand_req();
        delay_q.push_back(21);
        run_cycles(30);
        check_eq("ovr_count", ovr_cyc.size(), 1);
        check_eq("ovr_cyc", (ovr_cyc.size() > 0) ? ovr_cyc[0] : -1, 64);
        check_eq("ovr_resp_cyc", (resp_cyc.size() > 0) ? resp_cyc[0] : -1, 70);
        check_eq("ovr_sd_at_resp", sd_at[70], 1'b0);
        check_eq("ovr_sd_after", sd_at[71], 1'b1);

        // Reset at cycle 10 while requester 1 awaits its response.
        do_reset();
        dom_cfg = 2'b00;
        keep_busy = 1'b1;
        delay_q.push_back(0);
        delay_q.push_back(50);
        run_cycles(10);
        do_reset();
        dom_cfg = 2'b00;
        keep_busy = 1'b1;
        run_cycles(4);
        check_eq("post_rst_sel", (fire_sel.size() > 0) ? fire_sel[0] : -1, 0);
        check_eq("post_rst_cyc", (fire_cyc.size() > 0) ? fire_cyc[0] : -1, 1);

        // Requester withdraws while its grant is stalled by the bank.
        do_reset();
        dom_cfg = 2'b00;
        rdy_pct = 0;
        pend[0] = 1'b1;
        rq_msg[0] = rand_req();
        run_cycles(3);
        pend[0] = 1'b0;
        run_cycles(1);
        pend[1] = 1'b1;
        rq_msg[1] = rand_req();
        rdy_pct = 100;
        run_cycles(4);
        check_eq("abort_cyc", (fire_cyc.size() > 0) ? fire_cyc[0] : -1, 5);
        check_eq("abort_sel", (fire_sel.size() > 0) ? fire_sel[0] : -1, 1);

        // Randomized traffic, two domain assignments.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            dom_cfg = (pass == 0) ? 2'b10 : 2'b01;
            req_pct = 20;
            rdy_pct = 70;
            rsp_pct = 70;
            long_delays = 1'b1;
            run_cycles(1500);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
